// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared types, default sizes and helpers for the configuration
//               chain bitstream loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    // Default geometry of the configuration fabric.
    localparam int NUM_CHAINS_DEF = 12;
    localparam int CHAIN_LEN_DEF  = 2048;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Counter width able to hold 0..len inclusive.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_tail_checker.sv
`default_nettype none
// ============================================================================
// Module      : ccff_tail_checker
// Description : Per-chain comparison of the bit being shifted in against the
//               pre-shift chain tail, with sticky per-chain and summary error
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_tail_checker
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = NUM_CHAINS_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  check_en,
    input  logic [NUM_CHAINS-1:0] head,
    input  logic [NUM_CHAINS-1:0] tail,
    output logic [NUM_CHAINS-1:0] err_chain,
    output logic                  error
);

    logic [NUM_CHAINS-1:0] w_mismatch;
    logic [NUM_CHAINS-1:0] err_chain_d;
    logic [NUM_CHAINS-1:0] err_chain_q;
    logic                  error_d;
    logic                  error_q;

    // Accumulate mismatches while enabled; a new run clears the history.
    always_comb begin
        w_mismatch  = check_en ? (head ^ tail) : '0;
        err_chain_d = err_chain_q | w_mismatch;
        error_d     = error_q | (|w_mismatch);
        if (clear) begin
            err_chain_d = '0;
            error_d     = 1'b0;
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_chain_q <= '0;
            error_q     <= 1'b0;
        end else begin
            err_chain_q <= err_chain_d;
            error_q     <= error_d;
        end
    end

    assign err_chain = err_chain_q;
    assign error     = error_q;

endmodule : ccff_tail_checker
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_bitstream_loader
// Description : Streams a bitstream (one bit per chain per word) into the
//               configuration chains, producing a registered ccff_head and a
//               one-cycle prog_clk enable per accepted word, with an optional
//               second verify pass that checks ccff_tail.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = NUM_CHAINS_DEF,
    parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
    parameter int CNT_W      = cnt_w(CHAIN_LEN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [NUM_CHAINS-1:0] s_data,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  prog_clk_en,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [NUM_CHAINS-1:0] err_chain
);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  verify_q;
    logic                  verify_d;
    logic [NUM_CHAINS-1:0] head_q;
    logic [NUM_CHAINS-1:0] head_d;
    logic                  strobe_q;
    logic                  strobe_d;
    logic                  strobe_vfy_q;
    logic                  strobe_vfy_d;
    logic                  clear_chk;

    logic                  w_ready;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_shifting;

    // Words are only taken while a pass is open; the last handshake of a pass
    // is the one that brings the counter up to CHAIN_LEN.
    assign w_ready    = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    assign w_hs       = s_valid && w_ready;
    assign w_last     = w_hs && (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign w_shifting = w_ready || (state_q == ST_DRAIN);

    // Next-state, pass counter and verify-flag sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        verify_d  = verify_q;
        clear_chk = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    verify_d  = verify_en;
                    clear_chk = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_last) begin
                        if (verify_q) begin
                            state_d = ST_VERIFY;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                if (w_hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Head data and strobe: each accepted word becomes one strobe a cycle
    // later; strobes from verify-pass words are tagged for checking.
    always_comb begin
        head_d       = w_hs ? s_data : head_q;
        strobe_d     = w_hs;
        strobe_vfy_d = w_hs && (state_q == ST_VERIFY);
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            verify_q     <= 1'b0;
            head_q       <= '0;
            strobe_q     <= 1'b0;
            strobe_vfy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            verify_q     <= verify_d;
            head_q       <= head_d;
            strobe_q     <= strobe_d;
            strobe_vfy_q <= strobe_vfy_d;
        end
    end

    // The tail seen during a verify strobe is the bit about to be shifted
    // out, which must equal the bit now being shifted in.
    ccff_tail_checker #(
        .NUM_CHAINS (NUM_CHAINS)
    ) u_checker (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear_chk),
        .check_en  (strobe_q && strobe_vfy_q),
        .head      (head_q),
        .tail      (ccff_tail),
        .err_chain (err_chain),
        .error     (error)
    );

    assign s_ready       = w_ready;
    assign ccff_head     = head_q;
    assign prog_clk_en   = strobe_q;
    assign config_enable = w_shifting;
    assign busy          = w_shifting;
    assign done          = (state_q == ST_DONE);

endmodule : ccff_bitstream_loader
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_bitstream_loader
// Description : Scoreboard bench for ccff_bitstream_loader with a behavioural
//               shift-register model of the configuration chains.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    localparam int NC = 12;
    localparam int CL = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          verify_en;
    logic          s_valid;
    logic          s_ready;
    logic [NC-1:0] s_data;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail;
    logic          prog_clk_en;
    logic          config_enable;
    logic          busy;
    logic          done;
    logic          error;
    logic [NC-1:0] err_chain;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .verify_en     (verify_en),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .prog_clk_en   (prog_clk_en),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_chain     (err_chain)
    );

    // Configuration chains: one shift per strobe, tail is the oldest bit.
    logic [NC-1:0] chain [CL];
    logic [NC-1:0] fault_mask;
    always @(posedge clk) begin
        if (prog_clk_en) begin
            chain[0] <= ccff_head;
            for (int i = 1; i < CL; i++) chain[i] <= chain[i-1];
        end
    end
    assign ccff_tail = chain[CL-1] & ~fault_mask;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NC-1:0] word;
        int            cycle;
    } strobe_t;

    typedef struct {
        logic          err;
        logic [NC-1:0] errc;
    } result_t;

    strobe_t exp_q[$];
    result_t res_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      first_hs;
    bit      have_first;

    logic [NC-1:0] wa [4];
    logic [NC-1:0] wb [4];
    logic [NC-1:0] wc [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic v);
        start      = 1'b1;
        verify_en  = v;
        have_first = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        verify_en = 1'b0;
    endtask

    // Offer one word (called at a negedge); on acceptance queue the strobe
    // it must produce one cycle after the handshake.
    task automatic send(input logic [NC-1:0] w);
        int t = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            check("ready_timeout", 64'(s_ready), 64'd1);
        end else begin
            exp_q.push_back('{word: w, cycle: cyc + 1});
            if (!have_first) begin
                first_hs   = cyc + 1;
                have_first = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_done(output int dcyc);
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
        dcyc = cyc;
    endtask

    initial begin
        int d;
        wa = '{12'h001, 12'h002, 12'h004, 12'h008};
        wb = '{12'hABC, 12'h123, 12'hFFF, 12'h000};
        wc = '{12'h5A5, 12'h0F0, 12'h333, 12'hC3C};
        reset_n    = 1'b0;
        start      = 1'b0;
        verify_en  = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        fault_mask = '0;

        // Monitor: match every strobe and every done against the scoreboard.
        fork
            begin : monitor
                strobe_t e;
                result_t r;
                logic    done_d;
                done_d = 1'b0;
                forever begin
                    @(negedge clk);
                    if (prog_clk_en) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_strobe", 64'(prog_clk_en), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("strobe_head", 64'(ccff_head), 64'(e.word));
                            check("strobe_cycle", 64'(cyc), 64'(e.cycle));
                        end
                    end
                    if (done && !done_d) begin
                        if (res_q.size() == 0) begin
                            check("unexpected_done", 64'(done), 64'd0);
                        end else begin
                            r = res_q.pop_front();
                            check("error", 64'(error), 64'(r.err));
                            check("err_chain", 64'(err_chain), 64'(r.errc));
                            check("strobes_missing", 64'(exp_q.size()), 64'd0);
                        end
                    end
                    done_d = done;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({ccff_head, prog_clk_en, config_enable, s_ready,
                                    busy, done, error, err_chain}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Load only, continuous stream.
        res_q.push_back('{err: 1'b0, errc: '0});
        do_start(1'b0);
        check("load_flags", 64'({busy, config_enable, s_ready, done}), 64'b1110);
        for (int i = 0; i < 4; i++) send(wa[i]);
        s_valid = 1'b0;
        wait_done(d);
        check("load_done_latency", 64'(d), 64'(first_hs + 4));
        for (int i = 0; i < CL; i++) check("chain_contents", 64'(chain[i]), 64'(wa[CL-1-i]));
        check("done_flags", 64'({busy, config_enable, s_ready}), 64'd0);

        // Load plus verify, healthy chains.
        res_q.push_back('{err: 1'b0, errc: '0});
        do_start(1'b1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) send(wb[i]);
        s_valid = 1'b0;
        wait_done(d);
        check("verify_done_latency", 64'(d), 64'(first_hs + 8));

        // Load plus verify with chain 5 tail stuck at 0.
        fault_mask = 12'h020;
        res_q.push_back('{err: 1'b1, errc: 12'h020});
        do_start(1'b1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) send(wb[i]);
        s_valid = 1'b0;
        wait_done(d);
        fault_mask = '0;

        // Backpressure gap mid-load, then an extra word that must be refused.
        res_q.push_back('{err: 1'b0, errc: '0});
        do_start(1'b0);
        send(wc[0]);
        send(wc[1]);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_no_strobe", 64'(prog_clk_en), 64'd0);
            check("gap_head_hold", 64'(ccff_head), 64'(wc[1]));
        end
        send(wc[2]);
        send(wc[3]);
        s_valid = 1'b1;
        s_data  = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            check("extra_word_refused", 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_done(d);

        // Reset after two handshakes, then a clean run.
        do_start(1'b0);
        send(wa[0]);
        send(wa[1]);
        s_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", 64'({ccff_head, prog_clk_en, config_enable, s_ready,
                                        busy, done, error, err_chain}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        res_q.push_back('{err: 1'b0, errc: '0});
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(wc[i]);
        s_valid = 1'b0;
        wait_done(d);

        // Start pulse while loading must be ignored.
        res_q.push_back('{err: 1'b0, errc: '0});
        do_start(1'b0);
        send(wa[0]);
        send(wa[1]);
        s_valid   = 1'b0;
        start     = 1'b1;
        verify_en = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        verify_en = 1'b0;
        check("busy_after_ignored_start", 64'(busy), 64'd1);
        send(wa[2]);
        send(wa[3]);
        s_valid = 1'b0;
        wait_done(d);
        repeat (6) @(negedge clk);
        check("no_pending_results", 64'(res_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ccff_bitstream_loader
`default_nettype wire
